// File: rtl/mux_scan_sequencer.sv
// mux_scan_sequencer: walks the enabled CH0..CH7/TEMP slots, drives the one-hot mux selects,
// waits SETTLE_CYCLES, captures MUX_IN and hands each sample downstream on valid/ready.
module mux_scan_sequencer #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DATA_W = 16
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              START,
    input  logic              ABORT,
    input  logic              CONT,
    input  logic [7:0]        CH_EN,
    input  logic              TEMP_EN,
    input  logic [DATA_W-1:0] MUX_IN,
    output logic [7:0]        ATMCHSEL,
    output logic              TEMPSEL,
    output logic [DATA_W-1:0] SAMPLE_DATA,
    output logic [3:0]        SAMPLE_ID,
    output logic              SAMPLE_VALID,
    input  logic              SAMPLE_READY,
    output logic              BUSY,
    output logic              SCAN_DONE
);
    typedef enum logic [1:0] {IDLE, SETTLE, HOLD} state_t;
    localparam logic [7:0] CNT_LOAD = 8'(SETTLE_CYCLES - 1);
    state_t            state_q, state_d;
    logic [8:0]        mask_q, new_mask;
    logic [3:0]        slot_q, nxt_slot, first_slot, go_slot;
    logic [7:0]        cnt_q, atm_q;
    logic              temp_q, valid_q, busy_q, done_q;
    logic [3:0]        id_q;
    logic [DATA_W-1:0] data_q;
    logic              nxt_ok, first_ok, hs, last, go, capture;
    assign new_mask = {TEMP_EN, CH_EN};
    // descending scans so the lowest qualifying slot is the one left standing
    always_comb begin
        nxt_ok     = 1'b0;
        nxt_slot   = '0;
        first_ok   = 1'b0;
        first_slot = '0;
        for (int n = 8; n >= 0; n--) begin
            if (mask_q[n] && 4'(n) > slot_q) begin
                nxt_ok   = 1'b1;
                nxt_slot = 4'(n);
            end
            if (new_mask[n]) begin
                first_ok   = 1'b1;
                first_slot = 4'(n);
            end
        end
    end
    assign capture = state_q == SETTLE && cnt_q == '0;
    assign hs      = state_q == HOLD && SAMPLE_READY;
    assign last    = hs && !nxt_ok;
    assign go      = (state_q == IDLE && START && first_ok) || (hs && nxt_ok) || (last && CONT && first_ok);
    assign go_slot = (hs && nxt_ok) ? nxt_slot : first_slot;
    assign state_d = ABORT ? IDLE : go ? SETTLE : capture ? HOLD : last ? IDLE : state_q;
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            mask_q  <= '0;
            slot_q  <= '0;
            cnt_q   <= '0;
            atm_q   <= '0;
            temp_q  <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            id_q    <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            busy_q  <= state_d != IDLE;
            done_q  <= !ABORT && last;
            if (ABORT) begin
                atm_q   <= '0;
                temp_q  <= 1'b0;
                valid_q <= 1'b0;
            end else begin
                if (go) begin
                    slot_q <= go_slot;
                    atm_q  <= go_slot[3] ? 8'd0 : 8'd1 << go_slot[2:0];
                    temp_q <= go_slot[3];
                    cnt_q  <= CNT_LOAD;
                end else if (last) begin
                    atm_q  <= '0;
                    temp_q <= 1'b0;
                end else if (state_q == SETTLE && cnt_q != '0) begin
                    cnt_q <= cnt_q - 8'd1;
                end
                if (go && !(hs && nxt_ok)) mask_q <= new_mask;
                if (capture) begin
                    data_q  <= MUX_IN;
                    id_q    <= slot_q;
                    valid_q <= 1'b1;
                end else if (hs) begin
                    valid_q <= 1'b0;
                end
            end
        end
    end
    assign ATMCHSEL     = atm_q;
    assign TEMPSEL      = temp_q;
    assign SAMPLE_DATA  = data_q;
    assign SAMPLE_ID    = id_q;
    assign SAMPLE_VALID = valid_q;
    assign BUSY         = busy_q;
    assign SCAN_DONE    = done_q;
endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb_mux_scan_sequencer: directed plus random scans checked each cycle against a
// timestamp/queue model of the scan schedule.
module tb_mux_scan_sequencer;
    localparam int S = 4;
    localparam int DW = 16;
    logic          CLK = 1'b0;
    logic          RST = 1'b0, START = 1'b0, ABORT = 1'b0, CONT = 1'b0, TEMP_EN = 1'b0, SAMPLE_READY = 1'b0;
    logic [7:0]    CH_EN = '0;
    logic [DW-1:0] MUX_IN = '0;
    logic [7:0]    ATMCHSEL;
    logic          TEMPSEL, SAMPLE_VALID, BUSY, SCAN_DONE;
    logic [DW-1:0] SAMPLE_DATA;
    logic [3:0]    SAMPLE_ID;
    always #5 CLK = ~CLK;
    mux_scan_sequencer #(.SETTLE_CYCLES(S), .DATA_W(DW)) dut (
        .CLK(CLK), .RST(RST), .START(START), .ABORT(ABORT), .CONT(CONT), .CH_EN(CH_EN),
        .TEMP_EN(TEMP_EN), .MUX_IN(MUX_IN), .ATMCHSEL(ATMCHSEL), .TEMPSEL(TEMPSEL),
        .SAMPLE_DATA(SAMPLE_DATA), .SAMPLE_ID(SAMPLE_ID), .SAMPLE_VALID(SAMPLE_VALID),
        .SAMPLE_READY(SAMPLE_READY), .BUSY(BUSY), .SCAN_DONE(SCAN_DONE)
    );
    int n_checks = 0, n_fail = 0, ncyc = 0, t0 = 0;
    bit cont_v = 0, temp_v = 0;
    logic [7:0] ch_v = '0;
    bit m_known = 0, m_busy = 0, m_valid = 0, m_done = 0;
    logic [3:0] m_id = '0;
    logic [DW-1:0] m_data = '0;
    int q[$];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 40) $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, ncyc);
        end
    endtask
    task automatic load(input logic [8:0] mask);
        q.delete();
        for (int s = 0; s < 9; s++) if (mask[s]) q.push_back(s);
    endtask
    task automatic step(input bit r, input bit st, input bit ab, input bit rdy);
        logic [8:0] mask;
        logic [8:0] exp_sel;
        logic [3:0] tag;
        @(negedge CLK);
        ncyc++;
        if (m_known) begin
            exp_sel = (m_busy && q.size() != 0) ? 9'(1) << q[0] : 9'd0;
            check("busy", 32'(BUSY), 32'(m_busy));
            check("done", 32'(SCAN_DONE), 32'(m_done));
            check("valid", 32'(SAMPLE_VALID), 32'(m_valid));
            check("sel", 32'({TEMPSEL, ATMCHSEL}), 32'(exp_sel));
            check("id", 32'(SAMPLE_ID), 32'(m_id));
            check("data", 32'(SAMPLE_DATA), 32'(m_data));
        end
        tag = 4'hf;
        for (int i = 0; i < 8; i++) if (ATMCHSEL[i]) tag = 4'(i);
        if (TEMPSEL) tag = 4'd8;
        MUX_IN = {tag, 12'(ncyc)};
        RST = r; START = st; ABORT = ab; SAMPLE_READY = rdy;
        CONT = cont_v; CH_EN = ch_v; TEMP_EN = temp_v;
        mask = {temp_v, ch_v};
        m_done = 0;
        if (r) begin
            m_known = 1; m_busy = 0; m_valid = 0; m_id = '0; m_data = '0;
            q.delete();
        end else if (ab) begin
            m_busy = 0; m_valid = 0;
            q.delete();
        end else if (!m_busy) begin
            if (st && mask != 0) begin
                load(mask); t0 = ncyc + 1; m_busy = 1;
            end
        end else if (!m_valid) begin
            if (ncyc + 1 == t0 + S) begin
                m_valid = 1; m_id = 4'(q[0]); m_data = {4'(q[0]), 12'(ncyc)};
            end
        end else if (rdy) begin
            m_valid = 0;
            void'(q.pop_front());
            if (q.size() != 0) t0 = ncyc + 1;
            else begin
                m_done = 1;
                if (cont_v && mask != 0) begin
                    load(mask); t0 = ncyc + 1;
                end else m_busy = 0;
            end
        end
    endtask
    initial begin
        step(1, 0, 0, 0); step(1, 0, 0, 0);
        ch_v = 8'h05; temp_v = 1; cont_v = 0;
        step(0, 1, 0, 1);
        repeat (22) step(0, 0, 0, 1);
        ch_v = 8'h80; temp_v = 0;
        step(0, 1, 0, 0);
        repeat (16) step(0, 0, 0, 0);
        repeat (4) step(0, 0, 0, 1);
        ch_v = 8'h03; cont_v = 1;
        step(0, 1, 0, 1);
        repeat (24) step(0, 0, 0, 1);
        ch_v = 8'h00;
        repeat (16) step(0, 0, 0, 1);
        cont_v = 0; ch_v = 8'h08;
        step(0, 1, 0, 1);
        repeat (2) step(0, 0, 0, 1);
        step(0, 0, 1, 1);
        step(0, 1, 1, 1);
        step(0, 0, 0, 1);
        ch_v = 8'h0c;
        step(0, 1, 0, 1);
        repeat (12) step(0, 0, 0, 1);
        ch_v = 8'h00; temp_v = 0;
        step(0, 1, 0, 1);
        repeat (3) step(0, 0, 0, 1);
        ch_v = 8'h41;
        step(0, 1, 0, 0);
        repeat (6) step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 1);
        repeat (12) step(0, 0, 0, 1);
        step(0, 1, 0, 1);
        repeat (3) step(0, 0, 0, 1);
        repeat (3) step(1, 0, 0, 1);
        repeat (3000) begin
            if ($urandom_range(19) == 0) begin
                ch_v = ($urandom_range(7) == 0) ? 8'h00 : 8'($urandom);
                temp_v = 1'($urandom);
            end
            if ($urandom_range(49) == 0) cont_v = 1'($urandom);
            step($urandom_range(199) == 0, $urandom_range(7) == 0, $urandom_range(39) == 0, $urandom_range(2) != 0);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
